multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle ARM core.
- Sequences one shared instruction/data memory, one ALU and the register file across fetch, decode, execute, memory and writeback cycles.
- Decodes Op/Funct/Rd from the instruction register and drives the datapath selects.
- Stalls on a memory-ready handshake.
- Condition checking stays in the separate cond-logic block, which gates RegW, MemW, NextPC and Branch.

Parameters:
- STATE_W, 4, width of the State debug output and the internal state register.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- Op  in  2  instruction bits [27:26], taken from the IR
- Funct  in  6  instruction bits [25:20]
- Rd  in  4  instruction bits [15:12]
- MemReady  in  1  memory completes the current access this cycle
- IRWrite  out  1  load the IR
- NextPC  out  1  PC update request (PC+4)
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result
- ALUSrcA  out  1  ALU A select: 0 = Rn, 1 = PC
- ALUSrcB  out  2  ALU B select: 00 = Rm, 01 = ExtImm, 10 = constant 4
- ResultSrc  out  2  result select: 00 = ALUOut register, 01 = read data, 10 = ALU direct
- ImmSrc  out  2  extend select; equals Op
- RegSrc  out  2  register-address selects: bit0 = (Op==10), bit1 = (Op==01)
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- FlagW  out  2  flag-write enables: [1] = NZ, [0] = CV
- NoWrite  out  1  suppress register writeback (CMP)
- RegW  out  1  register write request
- MemW  out  1  memory write request
- Branch  out  1  branch request
- PCS  out  1  = ((Rd==4'hF) & RegW) | Branch
- Illegal  out  1  unimplemented opcode trapped
- State  out  STATE_W  current state, for debug

Behaviour:
- Output style: Moore outputs decoded from the state register.
  - IRWrite and NextPC are additionally ANDed with MemReady.
  - Every output not listed for a state is 0.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, TRAP=10.
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=NextPC=MemReady.
  - MemReady=0: stay in FETCH.
  - MemReady=1: go to DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (computes PC+8). Next state by Op:
  - 00 with Funct[5]=1 -> EXECI
  - 00 with Funct[5]=0 -> EXECR
  - 01 -> MEMADR
  - 10 -> BRANCH
  - 11 -> TRAP
- MEMADR: ALUSrcA=0, ALUSrcB=01. Funct[0]=1 -> MEMRD; Funct[0]=0 -> MEMWR.
- MEMRD: AdrSrc=1, ResultSrc=00. Stay while MemReady=0; MemReady=1 -> MEMWB.
- MEMWB: ResultSrc=01, RegW=1. Next: FETCH.
- MEMWR: AdrSrc=1, ResultSrc=00, MemW=1.
  - MemW is held high for every stall cycle.
  - MemReady=1 -> FETCH.
- EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1. Next: ALUWB.
- EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1. Next: ALUWB.
- ALUWB: ResultSrc=00, RegW=1, ALUOp=1 (keeps NoWrite/FlagW valid). Next: FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1. Next: FETCH.
- TRAP: Illegal=1; all request outputs are 0. Stays in TRAP until reset.
- ALU decode (internal ALUOp):
  - ALUOp=1, Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP -> SUB.
  - ALUOp=1, any other Funct[4:1]: ALUControl=00 and the FSM goes to TRAP on the next edge; no writeback occurs.
  - FlagW[1] = Funct[0].
  - FlagW[0] = Funct[0] & arithmetic & ~CMP.
  - NoWrite = CMP.
  - ALUOp=0: ALUControl=00, FlagW=00, NoWrite=0.
- Reset:
  - Asynchronous assertion forces FETCH immediately, including mid-access (e.g. in MEMWR: MemW drops at once).
  - During reset all outputs take FETCH values with IRWrite and NextPC forced to 0.
  - Operation resumes on the first rising clk edge after reset deasserts.
- Latency in cycles with no stalls: data processing 4, LDR 5, STR 4, B 3. Each MemReady=0 cycle adds one cycle.
- Inputs sampled only on rising clk; Op/Funct/Rd are stable after DECODE because the IR does not change.

Optional Feature:
- Macro: MC_PERF_COUNTERS_EN.
- Defined:
  - Adds output InstrCount (32-bit) and output StallCount (32-bit), both reset to 0.
  - InstrCount increments on every transition into FETCH from MEMWB, MEMWR, ALUWB or BRANCH.
  - StallCount increments on every cycle in FETCH, MEMRD or MEMWR with MemReady=0.
  - Both counters wrap at 2^32.
- Undefined: the ports and counters do not exist.

Test Plan:
- ADD register (Op=00, Funct=001000), MemReady=1 throughout -> states FETCH, DECODE, EXECR, ALUWB, FETCH; ALUControl=00 in EXECR; RegW=1 for exactly one cycle.
- CMP immediate (Op=00, Funct=110101) -> EXECI; ALUControl=01, NoWrite=1, FlagW=10 in EXECI/ALUWB.
- LDR (Op=01, Funct=011001), MemReady low 2 cycles in MEMRD -> MEMRD held 3 cycles, AdrSrc=1; then MEMWB with ResultSrc=01, RegW=1. Total 7 cycles.
- STR with Rd=15 (Op=01, Funct=011000), MemReady=0 for 3 cycles -> MemW=1 for 4 consecutive cycles; PCS=0; back to FETCH.
- Branch (Op=10) -> BRANCH with Branch=1, PCS=1, ResultSrc=10; FETCH follows. Op=11 -> TRAP with Illegal=1 held for 10 cycles until reset.
- reset pulled low mid-MEMWR -> State=0 and MemW=0 without a clock edge; FETCH resumes after release. With MC_PERF_COUNTERS_EN defined, InstrCount=0 after reset.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: main sequencing FSM and ALU decoder for the multicycle ARM core.
// Optional perf counters (InstrCount/StallCount) built when MC_PERF_COUNTERS_EN is defined.
module multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  input  logic [3:0]         Rd,
  input  logic               MemReady,
  output logic               IRWrite,
  output logic               NextPC,
  output logic               AdrSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         RegSrc,
  output logic [1:0]         ALUControl,
  output logic [1:0]         FlagW,
  output logic               NoWrite,
  output logic               RegW,
  output logic               MemW,
  output logic               Branch,
  output logic               PCS,
  output logic               Illegal,
  output logic [STATE_W-1:0] State
`ifdef MC_PERF_COUNTERS_EN
  ,
  output logic [31:0]        InstrCount,
  output logic [31:0]        StallCount
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_alu_op;
  logic   w_alu_bad;
  logic   w_arith;
  logic   w_cmp;

  assign State  = STATE_W'(r_state);
  assign ImmSrc = Op;
  assign RegSrc = {Op == 2'b01, Op == 2'b10};
  assign PCS    = ((Rd == 4'hF) & RegW) | Branch;

  assign w_alu_op = (r_state == S_EXECR) |
                    (r_state == S_EXECI) |
                    (r_state == S_ALUWB);

  // State register; reset drops straight back to FETCH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Funct[4:1] command decode, independent of state so the FSM can trap on it
  always_comb begin
    w_alu_bad  = 1'b0;
    w_arith    = 1'b0;
    w_cmp      = 1'b0;
    ALUControl = 2'b00;
    unique case (Funct[4:1])
      4'b0100: begin ALUControl = 2'b00; w_arith = 1'b1; end
      4'b0010: begin ALUControl = 2'b01; w_arith = 1'b1; end
      4'b0000: ALUControl = 2'b10;
      4'b1100: ALUControl = 2'b11;
      4'b1010: begin ALUControl = 2'b01; w_cmp = 1'b1; end
      default: w_alu_bad = 1'b1;
    endcase
    if (!w_alu_op) ALUControl = 2'b00;
  end

  // Flag-write and writeback-suppress, only meaningful under ALUOp
  always_comb begin
    FlagW   = 2'b00;
    NoWrite = 1'b0;
    if (w_alu_op && !w_alu_bad) begin
      FlagW   = {Funct[0], Funct[0] & w_arith & ~w_cmp};
      NoWrite = w_cmp;
    end
  end

  // Next-state and Moore datapath controls
  always_comb begin
    w_next    = r_state;
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    Illegal   = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady & reset;
        NextPC    = MemReady & reset;
        if (MemReady) w_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        unique case (Op)
          2'b00: w_next = Funct[5] ? S_EXECI : S_EXECR;
          2'b01: w_next = S_MEMADR;
          2'b10: w_next = S_BRANCH;
          2'b11: w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        w_next  = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
        if (MemReady) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
        w_next    = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
        if (MemReady) w_next = S_FETCH;
      end
      S_EXECR: begin
        w_next = w_alu_bad ? S_TRAP : S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcB = 2'b01;
        w_next  = w_alu_bad ? S_TRAP : S_ALUWB;
      end
      S_ALUWB: begin
        RegW   = ~w_alu_bad;
        w_next = w_alu_bad ? S_TRAP : S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
        w_next    = S_FETCH;
      end
      S_TRAP: begin
        Illegal = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

`ifdef MC_PERF_COUNTERS_EN
  logic [31:0] r_instr_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_instr_done;
  logic        w_stall;

  assign w_instr_done = (w_next == S_FETCH) &
                        ((r_state == S_MEMWB) | (r_state == S_MEMWR) |
                         (r_state == S_ALUWB) | (r_state == S_BRANCH));
  assign w_stall      = ~MemReady &
                        ((r_state == S_FETCH) | (r_state == S_MEMRD) |
                         (r_state == S_MEMWR));
  assign InstrCount   = r_instr_cnt;
  assign StallCount   = r_stall_cnt;

  // Retired-instruction and memory-stall counters, free-running wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (w_instr_done) r_instr_cnt <= r_instr_cnt + 32'd1;
      if (w_stall)      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench for the multicycle control FSM.
// Per-instruction expectations are queued by stimulus and checked by a monitor.
module tb_multicycle_control;

  localparam int FETCH  = 0;
  localparam int DECODE = 1;
  localparam int MEMADR = 2;
  localparam int MEMRD  = 3;
  localparam int MEMWB  = 4;
  localparam int MEMWR  = 5;
  localparam int EXECR  = 6;
  localparam int EXECI  = 7;
  localparam int ALUWB  = 8;
  localparam int BRANCH = 9;
  localparam int TRAP   = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       MemReady;
  logic       IRWrite, NextPC, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, FlagW;
  logic       NoWrite, RegW, MemW, Branch, PCS, Illegal;
  logic [3:0] State;
`ifdef MC_PERF_COUNTERS_EN
  logic [31:0] InstrCount, StallCount;
`endif

  multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .MemReady(MemReady), .IRWrite(IRWrite), .NextPC(NextPC),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ALUControl(ALUControl), .FlagW(FlagW), .NoWrite(NoWrite),
    .RegW(RegW), .MemW(MemW), .Branch(Branch), .PCS(PCS),
    .Illegal(Illegal),
`ifdef MC_PERF_COUNTERS_EN
    .InstrCount(InstrCount), .StallCount(StallCount),
`endif
    .State(State)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic [63:0] st;
    int          regw, memw, br, pcs, adr, rd01, irw, npc, bad;
    int          alu, flw, nw;
  } rec_t;

  rec_t sbq[$];
  rec_t mon;
  int   mon_last;
  bit   mon_en = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_done, n_stall;

  function automatic rec_t clr();
    rec_t r;
    r.len = 0; r.st = '0; r.regw = 0; r.memw = 0; r.br = 0;
    r.pcs = 0; r.adr = 0; r.rd01 = 0; r.irw = 0; r.npc = 0;
    r.bad = 0; r.alu = 0; r.flw = 0; r.nw = 0;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Spec command table for the data-processing ALU
  function automatic void ref_alu(input logic [3:0] c, output int ctl,
                                  output bit ar, output bit cm);
    ctl = 0; ar = 0; cm = 0;
    case (c)
      4'b0100: begin ctl = 0; ar = 1; end
      4'b0010: begin ctl = 1; ar = 1; end
      4'b0000: ctl = 2;
      4'b1100: ctl = 3;
      4'b1010: begin ctl = 1; cm = 1; end
      default: ctl = 0;
    endcase
  endfunction

  // Reference: phase lengths and per-instruction totals from the spec rules
  task automatic run_instr(input logic [1:0] op, input logic [5:0] fn,
                           input logic [3:0] rd, input int fs, input int ms);
    rec_t e;
    int   seq[$];
    bit   mr[$];
    int   ctl;
    bit   ar, cm;
    e = clr();
    for (int i = 0; i < fs; i++) begin seq.push_back(FETCH); mr.push_back(0); end
    seq.push_back(FETCH);  mr.push_back(1);
    seq.push_back(DECODE); mr.push_back(1'($urandom));
    e.irw = 1; e.npc = 1;
    case (op)
      2'b00: begin
        seq.push_back(fn[5] ? EXECI : EXECR); mr.push_back(1'($urandom));
        seq.push_back(ALUWB);                 mr.push_back(1'($urandom));
        ref_alu(fn[4:1], ctl, ar, cm);
        e.regw = 1;
        e.alu  = ctl;
        e.flw  = {fn[0], fn[0] & ar & ~cm};
        e.nw   = cm;
        e.pcs  = (rd == 4'hF);
      end
      2'b01: begin
        seq.push_back(MEMADR); mr.push_back(1'($urandom));
        for (int i = 0; i < ms; i++) begin
          seq.push_back(fn[0] ? MEMRD : MEMWR); mr.push_back(0);
        end
        seq.push_back(fn[0] ? MEMRD : MEMWR); mr.push_back(1);
        e.adr = ms + 1;
        if (fn[0]) begin
          seq.push_back(MEMWB); mr.push_back(1'($urandom));
          e.regw = 1; e.rd01 = 1; e.pcs = (rd == 4'hF);
        end else begin
          e.memw = ms + 1;
        end
        n_stall += ms;
      end
      default: begin
        seq.push_back(BRANCH); mr.push_back(1'($urandom));
        e.br = 1; e.pcs = 1;
      end
    endcase
    n_stall += fs;
    n_done++;
    e.len = seq.size();
    for (int i = 0; i < seq.size() && i < 16; i++) e.st[4*i +: 4] = 4'(seq[i]);
    sbq.push_back(e);
    for (int k = 0; k < seq.size(); k++) begin
      Op = op; Funct = fn; Rd = rd; MemReady = mr[k];
      cyc();
    end
  endtask

  task automatic drain();
    MemReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (sbq.size() == 0) break;
    end
    if (sbq.size() != 0) begin
      chk("drain_left", sbq.size(), 0);
      sbq.delete();
    end
    cyc();
  endtask

  // Monitor: an instruction ends when the FSM re-enters FETCH
  always @(negedge clk) begin
    if (!mon_en || !reset) begin
      mon = clr();
      mon_last = FETCH;
    end else begin
      if (int'(State) == FETCH && mon_last != FETCH && mon.len > 0) begin
        if (sbq.size() == 0) begin
          chk("unexpected_instr", 1, 0);
        end else begin
          rec_t e;
          e = sbq.pop_front();
          chk("len", mon.len, e.len);
          chk("states_lo", int'(mon.st[31:0]), int'(e.st[31:0]));
          chk("states_hi", int'(mon.st[63:32]), int'(e.st[63:32]));
          chk("regw_cycles", mon.regw, e.regw);
          chk("memw_cycles", mon.memw, e.memw);
          chk("branch_cycles", mon.br, e.br);
          chk("pcs_cycles", mon.pcs, e.pcs);
          chk("adrsrc_cycles", mon.adr, e.adr);
          chk("rsrc01_cycles", mon.rd01, e.rd01);
          chk("irwrite_cycles", mon.irw, e.irw);
          chk("nextpc_cycles", mon.npc, e.npc);
          chk("decode_bad", mon.bad, e.bad);
          chk("alucontrol", mon.alu, e.alu);
          chk("flagw", mon.flw, e.flw);
          chk("nowrite", mon.nw, e.nw);
        end
        mon = clr();
      end
      if (mon.len < 16) mon.st[4*mon.len +: 4] = State;
      mon.len++;
      mon.regw += int'(RegW);
      mon.memw += int'(MemW);
      mon.br   += int'(Branch);
      mon.pcs  += int'(PCS);
      mon.adr  += int'(AdrSrc);
      mon.rd01 += int'(ResultSrc == 2'b01);
      mon.irw  += int'(IRWrite);
      mon.npc  += int'(NextPC);
      mon.bad  += int'(Illegal || ImmSrc !== Op ||
                       RegSrc !== {Op == 2'b01, Op == 2'b10});
      if (RegW) begin
        mon.alu = int'(ALUControl);
        mon.flw = int'(FlagW);
        mon.nw  = int'(NoWrite);
      end
      mon_last = int'(State);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] cmds[5];
    logic [1:0] op;
    logic [5:0] fn;
    cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
    reset = 1'b1; MemReady = 1'b1; Op = 2'b00; Funct = 6'd0; Rd = 4'd0;
    #1 reset = 1'b0;
    #1;
    chk("rst_state", int'(State), FETCH);
    chk("rst_irwrite", int'(IRWrite), 0);
    chk("rst_nextpc", int'(NextPC), 0);
    chk("rst_srcs", int'({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}), 7'b0_1_10_10);
    chk("rst_reqs", int'({RegW, MemW, Branch, Illegal}), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; mon_en = 1'b1; n_done = 0; n_stall = 0;

    run_instr(2'b00, 6'b001000, 4'd3, 0, 0);
    run_instr(2'b00, 6'b110101, 4'd0, 0, 0);
    run_instr(2'b01, 6'b011001, 4'd2, 0, 2);
    run_instr(2'b01, 6'b011000, 4'hF, 0, 3);
    run_instr(2'b10, 6'($urandom), 4'd0, 0, 0);
    run_instr(2'b01, 6'b011001, 4'hF, 1, 0);
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 2));
      if (op == 2'b00) fn = {1'($urandom), cmds[$urandom_range(0, 4)], 1'($urandom)};
      else             fn = 6'($urandom);
      run_instr(op, fn, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end
`ifdef MC_PERF_COUNTERS_EN
    chk("instr_count", int'(InstrCount), n_done);
    chk("stall_count", int'(StallCount), n_stall);
`endif
    drain();
    mon_en = 1'b0;

    Op = 2'b11; Funct = 6'($urandom); MemReady = 1'b1;
    cyc();
    cyc();
    for (int i = 0; i < 10; i++) begin
      MemReady = 1'($urandom);
      #2;
      chk("trap_hold", int'({State, Illegal, RegW, MemW, Branch, IRWrite, NextPC, PCS}),
          int'({4'd10, 1'b1, 6'b0}));
      cyc();
    end
    reset = 1'b0;
    #1;
    chk("trap_reset", int'({State, Illegal}), 0);
    cyc();
    reset = 1'b1;

    Op = 2'b00; Funct = 6'b000011; Rd = 4'd5; MemReady = 1'b1;
    cyc();
    cyc();
    #2;
    chk("badfn_exec", int'({State, ALUControl, RegW}), int'({4'd6, 2'b00, 1'b0}));
    cyc();
    #2;
    chk("badfn_trap", int'({State, RegW, Illegal}), int'({4'd10, 1'b0, 1'b1}));
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;

    Op = 2'b01; Funct = 6'b011000; Rd = 4'hF; MemReady = 1'b1;
    cyc();
    cyc();
    MemReady = 1'b0;
    cyc();
    cyc();
    #2;
    chk("memwr_before", int'({State, MemW, PCS}), int'({4'd5, 1'b1, 1'b0}));
    reset = 1'b0;
    #1;
    chk("memwr_async_rst", int'({State, MemW, IRWrite, NextPC}), 0);
`ifdef MC_PERF_COUNTERS_EN
    chk("rst_instr_count", int'(InstrCount), 0);
    chk("rst_stall_count", int'(StallCount), 0);
`endif
    @(posedge clk);
    #1 reset = 1'b1; mon_en = 1'b1; n_done = 0; n_stall = 0;
    run_instr(2'b00, 6'b011001, 4'd7, 1, 0);
`ifdef MC_PERF_COUNTERS_EN
    chk("resume_instr_count", int'(InstrCount), n_done);
`endif
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
